// File: rtl/pdm_mic_rx_if.sv
// PCM pair stream from the PDM receiver to the audio path.
// Ports: pcm_l/pcm_r (two's complement samples), pcm_valid, pcm_ready.
// master = producer (drives data/valid), slave = consumer (drives ready).
interface pdm_mic_rx_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] pcm_l;
    logic [OUT_W-1:0] pcm_r;
    logic             pcm_valid;
    logic             pcm_ready;

    modport master (output pcm_l, output pcm_r, output pcm_valid, input pcm_ready);
    modport slave  (input pcm_l, input pcm_r, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/pdm_mic_rx.sv
// Stereo PDM mic receiver: drives mic_clk, splits the shared data line into
//   left (mic_clk high phase) and right (low phase) bits, and ones-count decimates.
// Latency: pcm_valid rises one clk after the DECIM-th right-bit sample.
// Backpressure: a new pair overwrites an unaccepted one and sets sticky overrun.
// Ports: clk, rst_n (async, active low), en, mic_clk, mic_data (async input),
//   pcm (pdm_mic_rx_if.master: pcm_l, pcm_r, pcm_valid, pcm_ready),
//   overrun (sticky), overrun_clr (single-cycle clear).
module pdm_mic_rx #(
    parameter int CLK_DIV = 16,
    parameter int DECIM   = 64,
    parameter int OUT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    output logic                mic_clk,
    input  logic                mic_data,
    pdm_mic_rx_if.master        pcm,
    output logic                overrun,
    input  logic                overrun_clr
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DECIM);
    localparam int ACC_W = CNT_W + 1;   // holds 0..DECIM inclusive

    logic             data_s1_q, data_s2_q;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             mic_clk_q, mic_clk_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [ACC_W-1:0] acc_l_q, acc_l_d;
    logic [ACC_W-1:0] acc_r_q, acc_r_d;
    logic [OUT_W-1:0] pcm_l_q, pcm_l_d;
    logic [OUT_W-1:0] pcm_r_q, pcm_r_d;
    logic             pcm_valid_q, pcm_valid_d;
    logic             overrun_q, overrun_d;

    logic             toggle;
    logic             smp_l;
    logic             smp_r;
    logic             win_done;
    logic             xfer;
    logic [ACC_W-1:0] acc_r_fin;

    // The bit is sampled on the toggle cycle, i.e. just before the mic_clk
    // edge, when the mic has held it stable for a full half-period.
    assign toggle    = en && (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign smp_l     = toggle && mic_clk_q;
    assign smp_r     = toggle && !mic_clk_q;
    assign win_done  = smp_r && (bit_cnt_q == CNT_W'(DECIM - 1));
    assign acc_r_fin = acc_r_q + ACC_W'(data_s2_q);
    assign xfer      = pcm_valid_q && pcm.pcm_ready;

    // Divider, accumulators and window counter
    always_comb begin
        div_cnt_d = div_cnt_q;
        mic_clk_d = mic_clk_q;
        bit_cnt_d = bit_cnt_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        if (!en) begin
            // Partial window is discarded; next enable starts clean.
            div_cnt_d = '0;
            mic_clk_d = 1'b0;
            bit_cnt_d = '0;
            acc_l_d   = '0;
            acc_r_d   = '0;
        end else begin
            div_cnt_d = toggle ? '0 : div_cnt_q + DIV_W'(1);
            if (toggle) begin
                mic_clk_d = !mic_clk_q;
            end
            if (smp_l) begin
                acc_l_d = acc_l_q + ACC_W'(data_s2_q);
            end
            if (smp_r) begin
                if (win_done) begin
                    acc_l_d   = '0;
                    acc_r_d   = '0;
                    bit_cnt_d = '0;
                end else begin
                    acc_r_d   = acc_r_fin;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Output holding register and overrun flag
    always_comb begin
        pcm_l_d     = pcm_l_q;
        pcm_r_d     = pcm_r_q;
        pcm_valid_d = pcm_valid_q;
        overrun_d   = overrun_q;
        if (xfer) begin
            pcm_valid_d = 1'b0;
        end
        if (win_done) begin
            // Zero-extend then subtract the midpoint; modular arithmetic in
            // OUT_W bits yields the sign-extended centred value.
            pcm_l_d     = OUT_W'(acc_l_q) - OUT_W'(DECIM / 2);
            pcm_r_d     = OUT_W'(acc_r_fin) - OUT_W'(DECIM / 2);
            pcm_valid_d = 1'b1;
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        // Set has priority over a same-cycle clear.
        if (win_done && pcm_valid_q && !pcm.pcm_ready) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_s1_q   <= 1'b0;
            data_s2_q   <= 1'b0;
            div_cnt_q   <= '0;
            mic_clk_q   <= 1'b0;
            bit_cnt_q   <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            pcm_l_q     <= '0;
            pcm_r_q     <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            data_s1_q   <= mic_data;
            data_s2_q   <= data_s1_q;
            div_cnt_q   <= div_cnt_d;
            mic_clk_q   <= mic_clk_d;
            bit_cnt_q   <= bit_cnt_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            pcm_l_q     <= pcm_l_d;
            pcm_r_q     <= pcm_r_d;
            pcm_valid_q <= pcm_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mic_clk       = mic_clk_q;
    assign pcm.pcm_l     = pcm_l_q;
    assign pcm.pcm_r     = pcm_r_q;
    assign pcm.pcm_valid = pcm_valid_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_pdm_mic_rx.sv
// Testbench for pdm_mic_rx: a mic-pair driver changes mic_data right after each
// mic_clk edge; expected pairs are queued by the stimulus (or by a bit-counting
// model for random streams) and a monitor compares every accepted pair.
`timescale 1ns/1ps
module tb_pdm_mic_rx;
    localparam int CLK_DIV = 16;
    localparam int DECIM   = 64;
    localparam int OUT_W   = 8;
    localparam int HALF    = CLK_DIV;
    localparam int WIN     = DECIM * 2 * CLK_DIV;                 // 2048
    // First window after enable closes on the 64th rising mic_clk edge
    // (127 half-periods), holding 63 left bits and 64 right bits.
    localparam int FIRST_PAIR = HALF + (DECIM - 1) * 2 * HALF;    // 2032

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic mic_data = 1'b0;
    logic overrun_clr = 1'b0;
    logic mic_clk;
    logic overrun;

    pdm_mic_rx_if #(.OUT_W(OUT_W)) pcm_if ();

    pdm_mic_rx #(.CLK_DIV(CLK_DIV), .DECIM(DECIM), .OUT_W(OUT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mic_clk     (mic_clk),
        .mic_data    (mic_data),
        .pcm         (pcm_if.master),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int l;
        int r;
    } pair_t;

    pair_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_pop   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    // ---------------- mic pair driver + counting model ----------------
    int   mode = 0;          // 0 constant, 1 alternating 1010.., 2 random
    int   l_const = 0;
    int   r_const = 0;
    int   lidx = 0;
    int   ridx = 0;
    logic cur_bit = 1'b0;
    logic mclk_prev = 1'b0;
    bit   model_on = 1'b0;
    int   m_l = 0;
    int   m_r = 0;
    int   m_n = 0;

    task automatic next_bit(input bit left, output logic b);
        case (mode)
            0: b = left ? l_const[0] : r_const[0];
            1: begin
                if (left) begin
                    b = (lidx % 2 == 0);
                    lidx++;
                end else begin
                    b = (ridx % 2 == 0);
                    ridx++;
                end
            end
            default: b = ($urandom_range(0, 1) == 1);
        endcase
    endtask

    always @(negedge clk) begin
        if (!en || !model_on) begin
            m_l = 0;
            m_r = 0;
            m_n = 0;
        end
        if (mic_clk !== mclk_prev) begin
            if (mic_clk) begin
                // rising edge: the right bit on the line was just taken
                if (en && model_on) begin
                    m_r += int'(cur_bit);
                    m_n++;
                    if (m_n == DECIM) begin
                        exp_q.push_back('{l: m_l - DECIM / 2, r: m_r - DECIM / 2});
                        m_l = 0;
                        m_r = 0;
                        m_n = 0;
                    end
                end
                next_bit(1'b1, cur_bit);
            end else begin
                if (en && model_on) m_l += int'(cur_bit);
                next_bit(1'b0, cur_bit);
            end
            mic_data = cur_bit;
        end
        mclk_prev = mic_clk;
    end

    // Only called with en=0 and mic_clk settled low.
    task automatic set_mode(input int m, input int lc, input int rc);
        mode    = m;
        l_const = lc;
        r_const = rc;
        lidx    = 0;
        ridx    = 0;
        next_bit(1'b0, cur_bit);
        mic_data = cur_bit;
    endtask

    // ---------------- scoreboard monitor ----------------
    always begin
        pair_t e;
        @(negedge clk);
        #1;
        if (rst_n && pcm_if.pcm_valid && pcm_if.pcm_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_pair: got l=%0d r=%0d, expected none",
                         $signed(pcm_if.pcm_l), $signed(pcm_if.pcm_r));
            end else begin
                e = exp_q.pop_front();
                check("pcm_l", int'($signed(pcm_if.pcm_l)), e.l);
                check("pcm_r", int'($signed(pcm_if.pcm_r)), e.r);
                n_pop++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (pcm_if.pcm_valid) return;
        end
        timeout(name);
    endtask

    task automatic wait_mclk(input string name, input logic val, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (mic_clk == val) return;
        end
        timeout(name);
    endtask

    task automatic wait_overrun(input string name, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (overrun) return;
        end
        timeout(name);
    endtask

    task automatic wait_drain(input string name, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) return;
        end
        timeout(name);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int t1;
        int hi;
        int p0;
        pcm_if.pcm_ready = 1'b0;
        set_mode(0, 1, 0);
        tick(3);
        rst_n = 1'b1;
        tick(3);

        // Reset state
        check("rst_mic_clk", int'(mic_clk), 0);
        check("rst_pcm_valid", int'(pcm_if.pcm_valid), 0);
        check("rst_pcm_l", int'(pcm_if.pcm_l), 0);
        check("rst_pcm_r", int'(pcm_if.pcm_r), 0);
        check("rst_overrun", int'(overrun), 0);

        // Full scale (L=1, R=0), period and latency
        exp_q.push_back('{l: 31, r: -32});   // 63 left bits in first window
        exp_q.push_back('{l: 32, r: -32});
        pcm_if.pcm_ready = 1'b1;
        en = 1'b1;
        t0 = cyc;
        wait_mclk("first_rise", 1'b1, 200);
        check("mic_clk_low_after_en", cyc - t0, HALF);
        t1 = cyc;
        wait_mclk("first_fall", 1'b0, 200);
        check("mic_clk_high_time", cyc - t1, HALF);
        wait_mclk("second_rise", 1'b1, 200);
        check("mic_clk_period", cyc - t1, 2 * HALF);
        wait_valid("fs_pair1", 2 * WIN);
        check("first_pair_latency", cyc - t0, FIRST_PAIR);
        t1 = cyc;
        tick(2);
        wait_valid("fs_pair2", 2 * WIN);
        check("pair_interval", cyc - t1, WIN);
        tick(2);
        en = 1'b0;
        tick(4);
        check("fs_drained", exp_q.size(), 0);

        // Alternating 1010.. per channel
        set_mode(1, 0, 0);
        exp_q.push_back('{l: 0, r: 0});
        exp_q.push_back('{l: 0, r: 0});
        en = 1'b1;
        wait_valid("alt_pair1", 2 * WIN);
        tick(2);
        wait_valid("alt_pair2", 2 * WIN);
        tick(2);
        en = 1'b0;
        tick(4);
        check("alt_drained", exp_q.size(), 0);

        // Backpressure: two windows unaccepted -> second (32) replaces first (31)
        set_mode(0, 1, 0);
        pcm_if.pcm_ready = 1'b0;
        en = 1'b1;
        wait_overrun("overrun_set", 3 * WIN);
        check("overrun_after_two_windows", int'(overrun), 1);
        check("valid_after_overwrite", int'(pcm_if.pcm_valid), 1);
        exp_q.push_back('{l: 32, r: -32});
        pcm_if.pcm_ready = 1'b1;
        tick(1);
        pcm_if.pcm_ready = 1'b0;
        check("overrun_sticky", int'(overrun), 1);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        check("overrun_cleared", int'(overrun), 0);
        // Ready raised exactly in the completing cycle of the next window
        exp_q.push_back('{l: 32, r: -32});
        exp_q.push_back('{l: 32, r: -32});
        wait_valid("bp_pair3", 2 * WIN);
        tick(WIN - 1);
        pcm_if.pcm_ready = 1'b1;
        tick(3);
        check("no_overrun_load_with_xfer", int'(overrun), 0);
        check("bp_drained", exp_q.size(), 0);
        en = 1'b0;
        tick(4);

        // Disable mid-window with a pending pair
        set_mode(0, 1, 1);
        pcm_if.pcm_ready = 1'b0;
        exp_q.push_back('{l: 31, r: 32});
        en = 1'b1;
        wait_valid("dis_pair1", 2 * WIN);
        for (int k = 0; k < 20; k++) begin
            wait_mclk("dis_low", 1'b0, 100);
            wait_mclk("dis_high", 1'b1, 100);
        end
        en = 1'b0;
        hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (mic_clk) hi++;
        end
        check("mic_clk_idle_when_disabled", hi, 0);
        check("valid_held_when_disabled", int'(pcm_if.pcm_valid), 1);
        check("data_held_when_disabled", int'($signed(pcm_if.pcm_l)), 31);
        exp_q.push_back('{l: 31, r: 32});    // only post-enable bits
        pcm_if.pcm_ready = 1'b1;
        en = 1'b1;
        wait_drain("dis_drain", 2 * WIN);
        tick(2);
        en = 1'b0;
        tick(4);

        // Random bitstream against the counting model
        set_mode(2, 0, 0);
        model_on = 1'b1;
        p0 = n_pop;
        en = 1'b1;
        for (int k = 0; k < 4 * WIN && (n_pop - p0) < 3; k++) @(negedge clk);
        check("random_pairs_seen", n_pop - p0, 3);
        en = 1'b0;
        tick(4);
        model_on = 1'b0;
        check("random_drained", exp_q.size(), 0);

        // Async reset mid-window and mid-handshake
        set_mode(0, 1, 0);
        pcm_if.pcm_ready = 1'b0;
        en = 1'b1;
        wait_overrun("pre_reset_overrun", 3 * WIN);
        tick(300);
        #3 rst_n = 1'b0;
        #1;
        check("arst_mic_clk", int'(mic_clk), 0);
        check("arst_pcm_valid", int'(pcm_if.pcm_valid), 0);
        check("arst_pcm_l", int'(pcm_if.pcm_l), 0);
        check("arst_pcm_r", int'(pcm_if.pcm_r), 0);
        check("arst_overrun", int'(overrun), 0);
        en = 1'b0;
        exp_q.delete();
        tick(3);
        rst_n = 1'b1;
        tick(3);
        exp_q.push_back('{l: 31, r: -32});
        pcm_if.pcm_ready = 1'b1;
        en = 1'b1;
        t0 = cyc;
        wait_valid("post_reset_pair", 2 * WIN);
        check("post_reset_latency", cyc - t0, FIRST_PAIR);
        tick(4);
        en = 1'b0;
        tick(10);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
